// File: rtl/secure_cmd_fsm.sv
// Guarded command sequencer: IDLE -> ARMED -> RUN -> DONE, with any protocol
// violation, timeout or corrupted state register trapping in FAULT until CLEAR.
module secure_cmd_fsm #(
    parameter int CMD_W       = 3,
    parameter int TIMEOUT_CYC = 16,
    parameter int RUN_CYC     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [CMD_W-1:0] cmd,
    output logic             cmd_ready,
    output logic [2:0]       state_out,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code
);
    localparam int MAX_CYC = (TIMEOUT_CYC > RUN_CYC) ? TIMEOUT_CYC : RUN_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(RUN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_ARMED = 3'b001,
        S_RUN   = 3'b010,
        S_DONE  = 3'b011,
        S_FAULT = 3'b100
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP, OP_ARM, OP_START, OP_ABORT, OP_CLEAR, OP_ILLEGAL
    } op_e;

    // Plain vector rather than state_e so the register can hold the unencoded
    // values that the recovery path has to catch.
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic             accept, expired;
    logic [CNT_W-1:0] cnt_dec;
    op_e              op;

    assign cmd_ready = (state_q != S_DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign expired   = (cnt_q == '0);
    assign cnt_dec   = expired ? cnt_q : cnt_q - CNT_W'(1);

    // An unaccepted command behaves exactly like NOP.
    always_comb begin
        op = OP_NOP;
        if (accept) begin
            case (cmd)
                CMD_W'(0): op = OP_NOP;
                CMD_W'(1): op = OP_ARM;
                CMD_W'(2): op = OP_START;
                CMD_W'(3): op = OP_ABORT;
                CMD_W'(4): op = OP_CLEAR;
                default:   op = OP_ILLEGAL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                case (op)
                    OP_ARM:     begin state_d = S_ARMED; cnt_d = TO_LOAD; end
                    OP_START:   begin state_d = S_FAULT; code_d = 2'd1; end
                    OP_ILLEGAL: begin state_d = S_FAULT; code_d = 2'd2; end
                    default:    ;
                endcase
            end
            S_ARMED: begin
                case (op)
                    OP_START:   begin state_d = S_RUN; cnt_d = RUN_LOAD; end
                    OP_ABORT:   state_d = S_IDLE;
                    OP_ILLEGAL: begin state_d = S_FAULT; code_d = 2'd2; end
                    default: begin
                        // Commands that do not leave ARMED also do not rearm the timer.
                        if (expired) begin
                            state_d = S_FAULT;
                            code_d  = 2'd0;
                        end else begin
                            cnt_d = cnt_dec;
                        end
                    end
                endcase
            end
            S_RUN: begin
                case (op)
                    OP_ABORT:          state_d = S_IDLE;
                    OP_ARM, OP_START:  begin state_d = S_FAULT; code_d = 2'd1; end
                    OP_ILLEGAL:        begin state_d = S_FAULT; code_d = 2'd2; end
                    default: begin
                        if (expired) state_d = S_DONE;
                        else         cnt_d   = cnt_dec;
                    end
                endcase
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: begin
                if (op == OP_CLEAR) begin
                    state_d = S_IDLE;
                    code_d  = 2'd0;
                end
            end
            default: begin
                state_d = S_FAULT;
                code_d  = 2'd3;
            end
        endcase
    end

    assign state_out = state_q;
    assign busy      = (state_q == S_ARMED) || (state_q == S_RUN);
    assign err       = (state_q == S_FAULT);
    assign err_code  = code_q;
endmodule

// File: tb/tb_secure_cmd_fsm.sv
// Randomized + directed bench: a cycle-level reference model predicts the
// outputs after each edge; a monitor pops and compares them.
module tb_secure_cmd_fsm;
    localparam int CMD_W = 3, TIMEOUT_CYC = 16, RUN_CYC = 8;

    logic             clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic [CMD_W-1:0] cmd = '0;
    logic             cmd_ready, busy, err;
    logic [2:0]       state_out;
    logic [1:0]       err_code;

    secure_cmd_fsm #(.CMD_W(CMD_W), .TIMEOUT_CYC(TIMEOUT_CYC), .RUN_CYC(RUN_CYC)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .state_out(state_out), .busy(busy),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct { int st; int code; } exp_t;
    exp_t exp_q[$];
    int n_cmp = 0, n_bad = 0;

    // Reference model: 0 idle, 1 armed, 2 run, 3 done, 4 fault, 7 corrupted.
    // age = number of cycles spent so far in the current state, counting this one.
    int m_st = 0, m_age = 0, m_code = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input int st, input int code);
        chk({tag, " state"}, int'(state_out), st);
        chk({tag, " busy"}, int'(busy), (st == 1 || st == 2) ? 1 : 0);
        chk({tag, " err"}, int'(err), (st == 4) ? 1 : 0);
        chk({tag, " err_code"}, int'(err_code), code);
        chk({tag, " cmd_ready"}, int'(cmd_ready), (st == 3) ? 0 : 1);
    endtask

    task automatic model_step(input bit v, input int c);
        bit acc, ill;
        int e, ns, nc;
        acc = v && (m_st != 3);
        e   = acc ? c : 0;
        ill = acc && (c > 4);
        ns  = m_st;
        nc  = m_code;
        case (m_st)
            0: if (e == 1) ns = 1;
               else if (e == 2) begin ns = 4; nc = 1; end
               else if (ill) begin ns = 4; nc = 2; end
            1: if (e == 2) ns = 2;
               else if (e == 3) ns = 0;
               else if (ill) begin ns = 4; nc = 2; end
               else if (m_age >= TIMEOUT_CYC) begin ns = 4; nc = 0; end
            2: if (e == 3) ns = 0;
               else if (e == 1 || e == 2) begin ns = 4; nc = 1; end
               else if (ill) begin ns = 4; nc = 2; end
               else if (m_age >= RUN_CYC) ns = 3;
            3: ns = 0;
            4: if (e == 4) begin ns = 0; nc = 0; end
            default: begin ns = 4; nc = 3; end
        endcase
        m_age  = (ns == m_st) ? m_age + 1 : 1;
        m_st   = ns;
        m_code = nc;
        exp_q.push_back('{st: m_st, code: m_code});
    endtask

    task automatic issue(input bit v, input int c);
        @(negedge clk);
        cmd_valid = v;
        cmd       = CMD_W'(c);
        model_step(v, c);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(1'b1, 0);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_outputs(tag, 0, 0);
        @(negedge clk);
        rst   = 1'b0;
        m_st  = 0; m_age = 0; m_code = 0;
    endtask

    // Monitor: every edge with an outstanding expectation is compared.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_t x;
                x = exp_q.pop_front();
                check_outputs("cyc", x.st, x.code);
            end
        end
    end

    initial begin
        #2 check_outputs("reset", 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Nominal run with a command offered during DONE
        issue(1, 1); issue(1, 2); nops(RUN_CYC - 1); issue(1, 0); issue(1, 1); nops(2);
        // Timeout, then recovery
        issue(1, 1); nops(TIMEOUT_CYC); nops(2); issue(1, 4); nops(1);
        // Illegal codes in IDLE, ARMED, RUN
        for (int c = 5; c <= 7; c++) begin
            issue(1, c); issue(1, 4);
            issue(1, 1); issue(1, c); issue(1, 4);
            issue(1, 1); issue(1, 2); issue(1, c); issue(1, 1); issue(1, 4);
        end
        // Sequence error, and ABORT on the final RUN cycle
        issue(1, 2); issue(1, 4);
        issue(1, 1); issue(1, 2); nops(RUN_CYC - 1); issue(1, 3); nops(1);
        // ARM/START inside RUN, ABORT from ARMED
        issue(1, 1); issue(1, 2); issue(1, 1); issue(1, 4);
        issue(1, 1); issue(1, 3); nops(1);

        // Corrupted state register
        @(negedge clk);
        cmd_valid = 1'b0;
        force dut.state_q = 3'b111;
        #1 release dut.state_q;
        m_st = 7;
        model_step(0, 0);
        issue(1, 0); issue(1, 4); nops(1);

        // Asynchronous reset mid-RUN and mid-FAULT
        issue(1, 1); issue(1, 2); nops(3);
        async_reset("rst_run");
        issue(1, 6);
        async_reset("rst_fault");
        nops(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int r, c;
            r = int'($urandom_range(0, 15));
            c = (r < 13) ? r % 5 : int'($urandom_range(5, 7));
            issue(($urandom % 4) != 0, c);
        end
        @(negedge clk);
        cmd_valid = 1'b0;

        repeat (4) @(posedge clk);
        #2 chk("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
